pipe_stage_skid: RTL and testbench

Parametrised, back-pressure-capable pipeline stage register that replaces the fixed-field ID/EX-style latches. It carries a control bundle and a data payload between two pipeline stages using a valid/ready handshake. A 2-entry skid buffer keeps in_ready a registered signal with no combinational path from out_ready. The stage also supports synchronous flush (bubble insertion) and a stall-cycle counter for performance debug.

---
 rtl/pipe_stage_skid.sv | 138 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with a 2-entry skid buffer.
// Carries a control bundle and a data payload between two stages. The main
// entry drives the outputs; the skid entry catches the one extra beat that
// arrives in the cycle after downstream stalls. This keeps in_ready a
// function of held state only, so there is no combinational path from
// out_ready to in_ready.
//
// Handshake: a transfer happens on an edge where valid and ready are both
// high. Upstream transfers when in_valid && in_ready. Downstream transfers
// when out_valid && out_ready. A valid source holds its ctrl/payload
// steady until that transfer. All state changes on the falling edge of clk.
//
// flush is synchronous and takes priority over any transfer in the same
// cycle. It empties the stage, drops that cycle's input and cancels that
// cycle's release.
module pipe_stage_skid #(
  parameter int CTRL_W        = 9,
  parameter int PAY_W         = 128,
  parameter int CLEAR_PAYLOAD = 1,
  parameter int STALL_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [PAY_W-1:0]   in_pay,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [PAY_W-1:0]   out_pay,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  // The occupancy state doubles as the state register and its debug view.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic [1:0]        state_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic [PAY_W-1:0]  main_pay;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [PAY_W-1:0]  skid_pay;

  logic main_valid;
  logic skid_valid;
  logic acc_fire;
  logic rel_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Valid bits and transfer qualifiers, all derived from the held state
  always_comb begin
    main_valid     = (state_q != ST_EMPTY);
    skid_valid     = (state_q == ST_FULL);
    in_ready       = !skid_valid && !rst;
    acc_fire       = in_valid && in_ready;
    rel_fire       = main_valid && out_ready;
    load_main_in   = acc_fire && ((state_q == ST_EMPTY) ||
                                  ((state_q == ST_ONE) && rel_fire));
    load_main_skid = (state_q == ST_FULL) && rel_fire;
    load_skid      = acc_fire && (state_q == ST_ONE) && !rel_fire;
  end

  // Outputs; ctrl is gated so a bubble never carries stale control bits
  always_comb begin
    out_valid = main_valid;
    out_ctrl  = main_valid ? main_ctrl : '0;
    out_pay   = main_pay;
    occupancy = state_q;
  end

  // Occupancy state machine: EMPTY -> ONE -> FULL and back, FIFO order
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc_fire) state_q <= ST_ONE;
        ST_ONE: begin
          if (acc_fire && !rel_fire)      state_q <= ST_FULL;
          else if (!acc_fire && rel_fire) state_q <= ST_EMPTY;
        end
        ST_FULL:  if (rel_fire) state_q <= ST_ONE;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

  // Main entry: loaded from the input, or promoted from skid on release
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_pay  <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      if (CLEAR_PAYLOAD != 0) main_pay <= '0;
    end else if (load_main_in) begin
      main_ctrl <= in_ctrl;
      main_pay  <= in_pay;
    end else if (load_main_skid) begin
      main_ctrl <= skid_ctrl;
      main_pay  <= skid_pay;
    end
  end

  // Skid entry: catches an accept that arrives while main is stalled
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      skid_ctrl <= '0;
      skid_pay  <= '0;
    end else if (flush) begin
      skid_ctrl <= '0;
      if (CLEAR_PAYLOAD != 0) skid_pay <= '0;
    end else if (load_skid) begin
      skid_ctrl <= in_ctrl;
      skid_pay  <= in_pay;
    end
  end

  // Saturating count of edges where a valid output is held off downstream
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!flush && main_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed scenarios plus a random run for the skid
// pipeline stage. Two instances share the stimulus: the default build and a
// build with a 3-bit stall counter and payload kept on flush. The reference
// is an ordered queue of entries plus saturating counters.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 9;
  localparam int PAY_W  = 128;
  localparam int EW     = CTRL_W + PAY_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [PAY_W-1:0]  in_pay = '0;

  logic              in_ready_a, out_valid_a;
  logic [CTRL_W-1:0] out_ctrl_a;
  logic [PAY_W-1:0]  out_pay_a;
  logic [1:0]        occ_a;
  logic [15:0]       stall_a;

  logic              in_ready_b, out_valid_b;
  logic [CTRL_W-1:0] out_ctrl_b;
  logic [PAY_W-1:0]  out_pay_b;
  logic [1:0]        occ_b;
  logic [2:0]        stall_b;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [EW-1:0]    exp_q[$];
  logic [PAY_W-1:0] disp_a;
  logic [PAY_W-1:0] disp_b;
  int unsigned      cnt_a;
  int unsigned      cnt_b;

  localparam logic [PAY_W-1:0] PA = 128'hAAAA_0001_0000_0000_0000_0000_0000_00A1;
  localparam logic [PAY_W-1:0] PB = 128'hBBBB_0002_0000_0000_0000_0000_0000_00B2;
  localparam logic [PAY_W-1:0] PC = 128'hCCCC_0003_0000_0000_0000_0000_0000_00C3;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .PAY_W(PAY_W), .CLEAR_PAYLOAD(1), .STALL_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_ctrl(in_ctrl), .in_pay(in_pay),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_ctrl(out_ctrl_a), .out_pay(out_pay_a),
    .occupancy(occ_a), .stall_cnt(stall_a)
  );

  pipe_stage_skid #(.CTRL_W(CTRL_W), .PAY_W(PAY_W), .CLEAR_PAYLOAD(0), .STALL_W(3)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_ctrl(in_ctrl), .in_pay(in_pay),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b), .out_pay(out_pay_b),
    .occupancy(occ_b), .stall_cnt(stall_b)
  );

  // Clock: DUT acts on negedge; bench drives and samples just after posedge
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    exp_q.delete();
    disp_a = '0;
    disp_b = '0;
    cnt_a  = 0;
    cnt_b  = 0;
  endtask

  // One falling edge of the reference: a FIFO of at most two entries
  task automatic model_edge();
    bit acc, rel;
    acc = in_valid && (exp_q.size() < 2);
    rel = (exp_q.size() > 0) && out_ready;
    if (flush) begin
      exp_q.delete();
      disp_a = '0;
    end else begin
      if ((exp_q.size() > 0) && !out_ready) begin
        if (cnt_a < 65535) cnt_a++;
        if (cnt_b < 7) cnt_b++;
      end
      if (rel) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({in_ctrl, in_pay});
      if (exp_q.size() > 0) begin
        disp_a = exp_q[0][PAY_W-1:0];
        disp_b = exp_q[0][PAY_W-1:0];
      end
    end
  endtask

  // Driver: apply inputs, let one falling edge pass, return just after posedge
  task automatic cycle(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [PAY_W-1:0] p, input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_pay    = p;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({out_valid_a, out_ctrl_a, out_pay_a, occ_a, stall_a, in_ready_a} !== '0 ||
        {out_valid_b, out_ctrl_b, out_pay_b, occ_b, stall_b, in_ready_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: a v=%0b c=%h occ=%0d st=%0d rdy=%0b b v=%0b c=%h occ=%0d st=%0d rdy=%0b, required all zero",
               out_valid_a, out_ctrl_a, occ_a, stall_a, in_ready_a, out_valid_b, out_ctrl_b, occ_b, stall_b, in_ready_b);
    end
    @(posedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got a=%0b b=%0b, required 1", in_ready_a, in_ready_b);
    end
  endtask

  task automatic test_stream();
    logic [PAY_W-1:0] pays[3];
    pays[0] = PA; pays[1] = PB; pays[2] = PC;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 9'h1A5 + 9'(i), pays[i], 1'b1, 1'b0);
      tests_run++;
      if (out_valid_a !== 1'b1 || out_ctrl_a !== 9'h1A5 + 9'(i) || out_pay_a !== pays[i] ||
          occ_a !== 2'd1 || stall_a !== 16'd0) begin
        tests_failed++;
        $display("FAIL stream_%0d: v=%0b c=%h p=%h occ=%0d st=%0d, required v=1 c=%h p=%h occ=1 st=0",
                 i, out_valid_a, out_ctrl_a, out_pay_a, occ_a, stall_a, 9'h1A5 + 9'(i), pays[i]);
      end
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    tests_run++;
    if (out_valid_a !== 1'b0 || out_ctrl_a !== '0 || occ_a !== 2'd0) begin
      tests_failed++;
      $display("FAIL stream_drain: v=%0b c=%h occ=%0d, required v=0 c=0 occ=0", out_valid_a, out_ctrl_a, occ_a);
    end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 9'h011, PA, 1'b0, 1'b0);
    tests_run++;
    if (occ_a !== 2'd1 || in_ready_a !== 1'b1 || stall_a !== 16'd0) begin
      tests_failed++;
      $display("FAIL bp_first: occ=%0d rdy=%0b st=%0d, required occ=1 rdy=1 st=0", occ_a, in_ready_a, stall_a);
    end
    cycle(1'b1, 9'h022, PB, 1'b0, 1'b0);
    tests_run++;
    if (occ_a !== 2'd2 || in_ready_a !== 1'b0 || out_pay_a !== PA || stall_a !== 16'd1) begin
      tests_failed++;
      $display("FAIL bp_full: occ=%0d rdy=%0b p=%h st=%0d, required occ=2 rdy=0 p=A st=1", occ_a, in_ready_a, out_pay_a, stall_a);
    end
    cycle(1'b1, 9'h033, PC, 1'b0, 1'b0);
    tests_run++;
    if (occ_a !== 2'd2 || out_ctrl_a !== 9'h011 || stall_a !== 16'd2) begin
      tests_failed++;
      $display("FAIL bp_hold: occ=%0d c=%h st=%0d, required occ=2 c=011 st=2", occ_a, out_ctrl_a, stall_a);
    end
    cycle(1'b1, 9'h033, PC, 1'b1, 1'b0);
    tests_run++;
    if (occ_a !== 2'd1 || out_ctrl_a !== 9'h022 || out_pay_a !== PB || in_ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release_a: occ=%0d c=%h p=%h rdy=%0b, required occ=1 c=022 p=B rdy=1", occ_a, out_ctrl_a, out_pay_a, in_ready_a);
    end
    cycle(1'b1, 9'h033, PC, 1'b1, 1'b0);
    tests_run++;
    if (occ_a !== 2'd1 || out_ctrl_a !== 9'h033 || out_pay_a !== PC || stall_a !== 16'd2 || stall_b !== 3'd2) begin
      tests_failed++;
      $display("FAIL bp_release_b: occ=%0d c=%h p=%h st=%0d/%0d, required occ=1 c=033 p=C st=2/2",
               occ_a, out_ctrl_a, out_pay_a, stall_a, stall_b);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush_full();
    cycle(1'b1, 9'h1FF, PA, 1'b0, 1'b0);
    cycle(1'b1, 9'h0F0, PB, 1'b0, 1'b0);
    tests_run++;
    if (occ_a !== 2'd2) begin
      tests_failed++;
      $display("FAIL flush_setup: occ=%0d, required 2", occ_a);
    end
    cycle(1'b1, 9'h155, PC, 1'b0, 1'b1);
    tests_run++;
    if (occ_a !== 2'd0 || out_valid_a !== 1'b0 || out_ctrl_a !== '0 || out_pay_a !== '0 || stall_a !== 16'd3) begin
      tests_failed++;
      $display("FAIL flush_clear: occ=%0d v=%0b c=%h p=%h st=%0d, required occ=0 v=0 c=0 p=0 st=3",
               occ_a, out_valid_a, out_ctrl_a, out_pay_a, stall_a);
    end
    tests_run++;
    if (occ_b !== 2'd0 || out_valid_b !== 1'b0 || out_ctrl_b !== '0 || out_pay_b !== PA || stall_b !== 3'd3) begin
      tests_failed++;
      $display("FAIL flush_hold_pay: occ=%0d v=%0b c=%h p=%h st=%0d, required occ=0 v=0 c=0 p=A st=3",
               occ_b, out_valid_b, out_ctrl_b, out_pay_b, stall_b);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    tests_run++;
    if (occ_a !== 2'd0 || out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drop_input: occ=%0d v=%0b, required occ=0 v=0", occ_a, out_valid_a);
    end
  endtask

  task automatic test_simul_accept_release();
    cycle(1'b1, 9'h0AA, PA, 1'b0, 1'b0);
    cycle(1'b1, 9'h0BB, PB, 1'b1, 1'b0);
    tests_run++;
    if (occ_a !== 2'd1 || out_ctrl_a !== 9'h0BB || out_pay_a !== PB || in_ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_acc_rel: occ=%0d c=%h p=%h rdy=%0b, required occ=1 c=0BB p=B rdy=1", occ_a, out_ctrl_a, out_pay_a, in_ready_a);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 9'h101, PA, 1'b0, 1'b0);
    cycle(1'b1, 9'h102, PB, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    tests_run++;
    if (occ_a !== 2'd2 || stall_a !== 16'd5) begin
      tests_failed++;
      $display("FAIL areset_setup: occ=%0d st=%0d, required occ=2 st=5", occ_a, stall_a);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({out_valid_a, out_ctrl_a, out_pay_a, occ_a, stall_a, in_ready_a} !== '0 ||
        {out_valid_b, out_ctrl_b, out_pay_b, occ_b, stall_b, in_ready_b} !== '0) begin
      tests_failed++;
      $display("FAIL areset_immediate: a v=%0b occ=%0d st=%0d rdy=%0b b v=%0b occ=%0d st=%0d rdy=%0b, required all zero",
               out_valid_a, occ_a, stall_a, in_ready_a, out_valid_b, occ_b, stall_b, in_ready_b);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready_a !== 1'b0 || occ_a !== 2'd0) begin
      tests_failed++;
      $display("FAIL areset_held: rdy=%0b occ=%0d, required rdy=0 occ=0", in_ready_a, occ_a);
    end
    rst = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_release: rdy=%0b/%0b, required 1/1", in_ready_a, in_ready_b);
    end
  endtask

  task automatic test_saturation();
    cycle(1'b1, 9'h077, PA, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      tests_run++;
      if (stall_b !== 3'((k > 7) ? 7 : k) || stall_a !== 16'(k)) begin
        tests_failed++;
        $display("FAIL stall_sat_%0d: got %0d/%0d, required %0d/%0d",
                 k, stall_a, stall_b, k, (k > 7) ? 7 : k);
      end
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic              ev;
    logic [CTRL_W-1:0] ec;
    logic [1:0]        eo;
    logic              er;
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 9'($urandom),
            {$urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      ev = exp_q.size() > 0;
      ec = ev ? exp_q[0][EW-1:PAY_W] : '0;
      eo = 2'(exp_q.size());
      er = exp_q.size() < 2;
      tests_run++;
      if (out_valid_a !== ev || out_ctrl_a !== ec || out_pay_a !== disp_a || occ_a !== eo ||
          in_ready_a !== er || stall_a !== 16'(cnt_a)) begin
        tests_failed++;
        $display("FAIL rand_a_%0d: v=%0b c=%h occ=%0d rdy=%0b st=%0d p=%h, required v=%0b c=%h occ=%0d rdy=%0b st=%0d p=%h",
                 n, out_valid_a, out_ctrl_a, occ_a, in_ready_a, stall_a, out_pay_a, ev, ec, eo, er, cnt_a, disp_a);
      end
      tests_run++;
      if (out_valid_b !== ev || out_ctrl_b !== ec || out_pay_b !== disp_b || occ_b !== eo ||
          in_ready_b !== er || stall_b !== 3'(cnt_b)) begin
        tests_failed++;
        $display("FAIL rand_b_%0d: v=%0b c=%h occ=%0d rdy=%0b st=%0d p=%h, required v=%0b c=%h occ=%0d rdy=%0b st=%0d p=%h",
                 n, out_valid_b, out_ctrl_b, occ_b, in_ready_b, stall_b, out_pay_b, ev, ec, eo, er, cnt_b, disp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_simul_accept_release();
    test_async_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
